// File: rtl/stencil3d_drain_if.sv
// Handshake bundle between the stencil kernel, the drain stage and the
// writeback/DMA sink. The drain connects through the slave modport; the
// master modport is the view of the surrounding environment.
interface stencil3d_drain_if #(
   parameter int FRAME_W = 1024,
   parameter int WORD_W  = 32,
   parameter int IDX_W   = $clog2(FRAME_W / WORD_W)
);
   logic               frame_valid;
   logic               frame_ready;
   logic [FRAME_W-1:0] frame_data;
   logic               m_valid;
   logic               m_ready;
   logic [WORD_W-1:0]  m_data;
   logic               m_last;
   logic [IDX_W-1:0]   m_index;
   logic               busy;
   logic [15:0]        frame_count;

   // Drain side: consumes frames, produces the word stream and status.
   modport slave (
      input  frame_valid, frame_data, m_ready,
      output frame_ready, m_valid, m_data, m_last, m_index, busy, frame_count
   );

   // Environment side: kernel plus sink.
   modport master (
      output frame_valid, frame_data, m_ready,
      input  frame_ready, m_valid, m_data, m_last, m_index, busy, frame_count
   );
endinterface

// File: rtl/stencil3d_drain.sv
// Output drain for the 3D stencil kernel: captures a whole solution frame
// into a shadow buffer and streams it out one word per handshake. The next
// frame can be accepted on the same cycle the last word leaves, so
// back-to-back frames stream without a bubble.
module stencil3d_drain #(
   parameter int FRAME_W = 1024,
   parameter int WORD_W  = 32
) (
   input logic              clk,
   input logic              rst,
   stencil3d_drain_if.slave bus
);

   localparam int NUM_WORDS = FRAME_W / WORD_W;
   localparam int IDX_W     = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] shadow_q;
   logic [WORD_W-1:0]  data_q, data_d;
   logic               last_q, last_d;
   logic [15:0]        frame_count_q, frame_count_d;

   logic               m_valid_s;
   logic               xfer_s;
   logic               last_xfer_s;
   logic               frame_ready_s;
   logic               accept_s;
   logic [IDX_W-1:0]   nxt_idx_s;
   logic [WORD_W-1:0]  nxt_word_s;
   logic [WORD_W-1:0]  first_word_s;

   // Handshake decode: word transfer, last-word transfer and frame accept.
   always_comb begin
      m_valid_s     = (state_q == ST_SEND);
      xfer_s        = m_valid_s && bus.m_ready;
      last_xfer_s   = xfer_s && (cnt_q == LAST_IDX);
      frame_ready_s = (state_q == ST_IDLE) || last_xfer_s;
      accept_s      = bus.frame_valid && frame_ready_s;
      nxt_idx_s     = cnt_q + ONE_IDX;
      nxt_word_s    = shadow_q[int'(nxt_idx_s) * WORD_W +: WORD_W];
      first_word_s  = bus.frame_data[WORD_W-1:0];
   end

   // Next-state logic: frame load, word advance and drained-frame counting.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      last_d        = last_q;
      frame_count_d = frame_count_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_SEND;
               cnt_d   = ZERO_IDX;
               data_d  = first_word_s;
               last_d  = (LAST_IDX == ZERO_IDX);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (last_xfer_s) begin
               frame_count_d = frame_count_q + 16'd1;
               if (accept_s) begin
                  // Reload on the same edge: the stream continues without a gap.
                  state_d = ST_SEND;
                  cnt_d   = ZERO_IDX;
                  data_d  = first_word_s;
                  last_d  = (LAST_IDX == ZERO_IDX);
               end else begin
                  state_d = ST_IDLE;
                  last_d  = 1'b0;
               end
            end else if (xfer_s) begin
               cnt_d  = nxt_idx_s;
               data_d = nxt_word_s;
               last_d = (nxt_idx_s == LAST_IDX);
            end else begin
               // Stalled: the presented word, index and last flag are held.
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = ZERO_IDX;
            last_d  = 1'b0;
         end
      endcase
   end

   // Control and output registers; reset discards any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= ZERO_IDX;
         data_q        <= {WORD_W{1'b0}};
         last_q        <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         last_q        <= last_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Shadow buffer: only written on accept, which never overlaps a held word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= {FRAME_W{1'b0}};
      end else if (accept_s) begin
         shadow_q <= bus.frame_data;
      end else begin
         shadow_q <= shadow_q;
      end
   end

   assign bus.frame_ready = frame_ready_s;
   assign bus.m_valid     = m_valid_s;
   assign bus.m_data      = data_q;
   assign bus.m_last      = last_q;
   assign bus.m_index     = cnt_q;
   assign bus.busy        = m_valid_s;
   assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_stencil3d_drain.sv
// Directed bench for stencil3d_drain with a word scoreboard: expected words
// are queued when a frame is accepted and compared while they are presented.
module tb_stencil3d_drain;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   rmode = 0;

   logic [37:0] q[$];
   logic [37:0] exp_w;
   logic [15:0] exp_count = 16'd0;

   stencil3d_drain_if #(.FRAME_W(1024), .WORD_W(32)) bus ();

   stencil3d_drain #(.FRAME_W(1024), .WORD_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [1023:0] mk(input logic [31:0] base, input logic [31:0] add);
      logic [1023:0] f;
      for (int n = 0; n < 32; n++) f[n*32 +: 32] = base + 32'(n) + add;
      return f;
   endfunction

   task automatic push_frame(input logic [1023:0] d);
      for (int n = 0; n < 32; n++) q.push_back({(n == 31), 5'(n), d[n*32 +: 32]});
   endtask

   // Sink: m_ready pattern selected by rmode, changed just after each edge.
   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every presented word must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && bus.m_valid === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_word", 64'd1, 64'd0);
         end else begin
            exp_w = q[0];
            check("m_data", 64'(bus.m_data), 64'(exp_w[31:0]));
            check("m_index", 64'(bus.m_index), 64'(exp_w[36:32]));
            check("m_last", 64'(bus.m_last), 64'(exp_w[37]));
            if (bus.m_ready === 1'b1) begin
               void'(q.pop_front());
               if (exp_w[37]) exp_count = exp_count + 16'd1;
            end
         end
      end
   end

   task automatic send_frame(input logic [1023:0] d, input bit holdoff, input string tag);
      bit got = 1'b0;
      @(posedge clk);
      #1;
      bus.frame_valid = 1'b1;
      bus.frame_data  = d;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (holdoff && i == 0) check({tag, "_ready_low"}, 64'(bus.frame_ready), 64'd0);
         if (bus.frame_ready === 1'b1) begin
            got = 1'b1;
            push_frame(d);
            if (holdoff)
               check({tag, "_accept_on_last"},
                     64'({bus.m_valid, bus.m_ready, bus.m_last}), 64'b111);
         end
      end
      check({tag, "_accepted"}, 64'(got), 64'd1);
      @(posedge clk);
      #1;
      bus.frame_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (q.size() == 0 && bus.m_valid === 1'b0) done = 1'b1;
      end
      check({tag, "_drained"}, 64'(done), 64'd1);
   endtask

   task automatic wait_index(input logic [4:0] k, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (bus.m_valid === 1'b1 && bus.m_index === k) seen = 1'b1;
      end
      check({tag, "_reached_index"}, 64'(seen), 64'd1);
   endtask

   initial begin
      rst             = 1'b1;
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_frame_ready", 64'(bus.frame_ready), 64'd1);
      check("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check("rst_m_last", 64'(bus.m_last), 64'd0);
      check("rst_m_index", 64'(bus.m_index), 64'd0);
      check("rst_m_data", 64'(bus.m_data), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_frame_count", 64'(bus.frame_count), 64'd0);

      // Single frame, words 1..32, sink always ready
      rmode = 1;
      send_frame(mk(32'd0, 32'd1), 1'b0, "single");
      @(negedge clk);
      check("single_latency_valid", 64'(bus.m_valid), 64'd1);
      check("single_latency_index", 64'(bus.m_index), 64'd0);
      check("single_latency_data", 64'(bus.m_data), 64'd1);
      check("single_busy", 64'(bus.busy), 64'd1);
      wait_drain("single");
      check("single_idle_busy", 64'(bus.busy), 64'd0);
      check("single_idle_ready", 64'(bus.frame_ready), 64'd1);
      check("single_count", 64'(bus.frame_count), 64'd1);

      // Random backpressure; scoreboard head is checked on every stall cycle
      rmode = 2;
      send_frame(mk(32'hA5A5_0000, 32'd7), 1'b0, "bp");
      wait_drain("bp");
      check("bp_count", 64'(bus.frame_count), 64'(exp_count));
      check("bp_count_abs", 64'(bus.frame_count), 64'd2);

      // Back-to-back: B offered while A drains, accepted with A's last word
      rmode = 1;
      send_frame(mk(32'd0, 32'd0), 1'b0, "b2b_a");
      send_frame(mk(32'h100, 32'd0), 1'b1, "b2b_b");
      @(negedge clk);
      check("b2b_no_gap_valid", 64'(bus.m_valid), 64'd1);
      check("b2b_no_gap_index", 64'(bus.m_index), 64'd0);
      check("b2b_no_gap_data", 64'(bus.m_data), 64'h100);
      wait_drain("b2b");
      check("b2b_count", 64'(bus.frame_count), 64'd4);

      // Hold-off: C offered at A's word 5, must wait for A's last transfer
      send_frame(mk(32'h200, 32'd0), 1'b0, "hold_a");
      wait_index(5'd5, "hold");
      send_frame(mk(32'h300, 32'd0), 1'b1, "hold_c");
      @(negedge clk);
      check("hold_c_word0", 64'(bus.m_data), 64'h300);
      wait_drain("hold");
      check("hold_count", 64'(bus.frame_count), 64'(exp_count));

      // Reset mid-frame after word 10 has transferred
      send_frame(mk(32'h400, 32'd0), 1'b0, "rst_d");
      wait_index(5'd10, "rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
      check("midrst_count", 64'(bus.frame_count), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_index", 64'(bus.m_index), 64'd0);
      q.delete();
      exp_count = 16'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(mk(32'h500, 32'd0), 1'b0, "post_rst");
      @(negedge clk);
      check("post_rst_index", 64'(bus.m_index), 64'd0);
      check("post_rst_data", 64'(bus.m_data), 64'h500);
      wait_drain("post_rst");
      check("post_rst_count", 64'(bus.frame_count), 64'd1);

      // Counter wrap: preload 0xFFFF, then drain one more frame
      force dut.frame_count_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_count_q;
      @(negedge clk);
      check("wrap_preload", 64'(bus.frame_count), 64'hFFFF);
      exp_count = 16'hFFFF;
      send_frame(mk(32'h600, 32'd0), 1'b0, "wrap");
      wait_drain("wrap");
      check("wrap_count", 64'(bus.frame_count), 64'(exp_count));
      check("wrap_zero", 64'(bus.frame_count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stencil3d_drain.md
# stencil3d_drain

Output drain stage placed directly downstream of the 3D stencil kernel. It captures one 1024-bit solution frame per handshake into a shadow buffer, then streams it out as 32-bit words over a valid/ready interface for the writeback/DMA path. Back-to-back frames are supported without bubbles. The kernel can start its next frame while the current one drains.

## Interface
- FRAME_W, 1024, width of the solution frame from the kernel.
- WORD_W, 32, width of one output word. FRAME_W must be an integer multiple of WORD_W.
- NUM_WORDS, FRAME_W/WORD_W (derived, 32), words per frame.
- IDX_W, clog2(NUM_WORDS) (derived, 5), width of the word index.

Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- frame_valid  in  1  kernel presents a complete frame on frame_data.
- frame_ready  out  1  drain accepts a frame this cycle.
- frame_data  in  FRAME_W  solution frame; word n = frame_data[n*WORD_W +: WORD_W].
- m_valid  out  1  output word valid.
- m_ready  in  1  sink accepts the output word.
- m_data  out  WORD_W  current output word.
- m_last  out  1  high with the final word (index NUM_WORDS-1) of a frame.
- m_index  out  IDX_W  index of the word currently on m_data.
- busy  out  1  a frame is held or draining (state SEND).
- frame_count  out  16  count of fully drained frames; wraps modulo 2^16.

## Operation
- States:
  - IDLE: no frame held. frame_ready=1, m_valid=0.
  - SEND: a frame is held and words are presented.
- Frame accept: frame_valid && frame_ready. frame_data is copied into the shadow buffer, the word counter is set to 0 and the state goes to SEND.
- Output handshake: a word transfers on m_valid && m_ready. On each transfer:
  - if it is not the last word, the word counter increments by 1;
  - if it is the last word, frame_count increments by 1.
- frame_ready = (state==IDLE) || (m_valid && m_ready && m_last). This is combinational from state, counter and m_ready.
- Last-word transfer with a simultaneous frame accept: the new frame loads, the counter returns to 0 and the state stays SEND. m_valid stays 1, so there is no bubble.
- Last-word transfer without a frame accept: the state goes to IDLE and m_valid drops.
- m_data = shadow buffer word selected by the counter. m_last = (counter==NUM_WORDS-1). m_index = counter.
- Once m_valid is asserted, m_data, m_last and m_index stay stable until the transfer completes. A new frame is never loaded over a held, untransferred word.
- frame_valid while frame_ready=0: the frame is not captured. The upstream kernel keeps frame_valid and frame_data stable until accepted.
- The drain does no arithmetic on the data; it is passed through bit-exact.
- busy = (state==SEND).

## Timing
- Reset values: state IDLE, m_valid 0, m_last 0, m_index 0, m_data 0, busy 0, frame_count 0. frame_ready reads 1 immediately after reset.
- Reset asserted mid-frame clears all registers immediately. The partial frame is discarded, and frame_count does not count it.
- Latency: a frame accepted at edge N gives m_valid=1 with word 0 in the cycle after edge N.
- Throughput: one word per cycle with m_ready held high. One frame takes NUM_WORDS cycles back-to-back.
- m_ready may be deasserted in any cycle. The held word repeats until accepted.
- m_ready may be high while m_valid=0; this has no effect.
- frame_count wraps from 0xFFFF to 0x0000 on the 65536th frame.

## Test plan
- Single frame, word n = n+1, m_ready=1 → 32 transfers with data 1..32 and m_index 0..31. m_last only on data 32. Then IDLE, busy=0, frame_count=1.
- Backpressure: m_ready pseudo-random at 50% → same word sequence, no duplicates or drops. m_data is stable during stall cycles.
- Back-to-back frames: frame A (n), then frame B (0x100+n) offered during A's last word → B word 0 directly follows A word 31 with no m_valid gap. frame_count=2.
- Busy hold-off: frame_valid asserted at A word 5 with frame C → frame_ready=0 until A's last transfer. C is captured then, and its word 0 is correct.
- Reset mid-frame: assert rst after word 10 is transferred → m_valid=0 and frame_count=0 at once. The next frame starts at index 0 with correct data.
- Counter wrap: preload via 65535 drained frames (or force), then drain one more → frame_count=0.
